// File: rtl/riscv_types_pkg.sv
// rtl/riscv_types_pkg.sv - branch prediction types shared by predictor, queue and execute
package riscv_types_pkg;

    localparam int BPQ_ADDR_WIDTH = 32;

    typedef struct packed {
        logic                      predict_taken;
        logic [BPQ_ADDR_WIDTH-1:0] predict_target;
        logic                      btb_hit;
    } branch_prediction_t;

    typedef struct packed {
        logic                      valid;
        logic [BPQ_ADDR_WIDTH-1:0] pc;
        logic                      taken;
        logic [BPQ_ADDR_WIDTH-1:0] target;
        logic                      mispredict;
    } branch_update_t;

    typedef struct packed {
        logic [BPQ_ADDR_WIDTH-1:0] pc;
        branch_prediction_t        pred;
    } bpq_entry_t;

endpackage

// File: rtl/bpq_perf_counter.sv
// rtl/bpq_perf_counter.sv - saturating 32-bit event counter
module bpq_perf_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    // count events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (inc_i && (count_o != 32'hFFFF_FFFF)) begin
            count_o <= count_o + 32'd1;
        end
    end

endmodule

// File: rtl/branch_pred_queue.sv
// rtl/branch_pred_queue.sv - in-order prediction queue with resolve/update/redirect (BPQ_STATS_EN adds counters)
module branch_pred_queue
    import riscv_types_pkg::*;
#(
    parameter int ADDR_WIDTH = BPQ_ADDR_WIDTH,
    parameter int DEPTH      = 8,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    input  logic [ADDR_WIDTH-1:0] push_pc_i,
    input  branch_prediction_t    push_pred_i,
    input  logic                  resolve_valid_i,
    input  logic                  resolve_taken_i,
    input  logic [ADDR_WIDTH-1:0] resolve_target_i,
    input  logic                  flush_i,
    output branch_update_t        update_o,
    output logic                  redirect_o,
    output logic [ADDR_WIDTH-1:0] redirect_pc_o,
    output logic                  resolve_err_o,
    output logic [CW-1:0]         count_o
`ifdef BPQ_STATS_EN
    ,
    output logic [31:0]           stat_branches_o,
    output logic [31:0]           stat_mispredicts_o
`endif
);

    bpq_entry_t      mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    bpq_entry_t      head_entry;
    logic            empty;
    logic            push_fire;
    logic            resolve_fire;
    logic            mispredict;
    logic            unused_btb_hit;

    assign empty          = (count == '0);
    assign push_ready_o   = (count != CW'(DEPTH));
    assign push_fire      = push_valid_i && push_ready_o;
    // A resolve on an empty queue is an error, never a bypass of a same-cycle push.
    assign resolve_fire   = resolve_valid_i && !empty && !flush_i;
    assign head_entry     = mem[head];
    assign unused_btb_hit = head_entry.pred.btb_hit;
    assign count_o        = count;

    // compare actual outcome against the stored prediction for the head entry
    always_comb begin
        mispredict = (head_entry.pred.predict_taken != resolve_taken_i) ||
                     (resolve_taken_i && (head_entry.pred.predict_target != resolve_target_i));
    end

    // pointer/occupancy update: flush beats mispredict squash beats normal push/pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i || (resolve_fire && mispredict)) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_fire) begin
                tail <= tail + PW'(1);
            end
            if (resolve_fire) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(push_fire) - CW'(resolve_fire);
        end
    end

    // entry storage; a dropped push may write the slot but tail never advances past it
    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            mem[tail] <= '{pc: push_pc_i, pred: push_pred_i};
        end
    end

    // registered predictor update and front-end redirect, one cycle after the resolve edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            update_o      <= '0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
        end else begin
            if (resolve_fire) begin
                update_o.valid      <= 1'b1;
                update_o.pc         <= head_entry.pc;
                update_o.taken      <= resolve_taken_i;
                update_o.target     <= resolve_target_i;
                update_o.mispredict <= mispredict;
            end else begin
                update_o <= '0;
            end
            redirect_o <= resolve_fire && mispredict;
            if (resolve_fire && mispredict) begin
                redirect_pc_o <= resolve_taken_i ? resolve_target_i
                                                 : head_entry.pc + ADDR_WIDTH'(4);
            end
        end
    end

    // sticky error: execute resolved a branch the queue never held
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resolve_err_o <= 1'b0;
        end else if (resolve_valid_i && empty) begin
            resolve_err_o <= 1'b1;
        end
    end

`ifdef BPQ_STATS_EN
    bpq_perf_counter u_stat_branches (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (update_o.valid),
        .count_o (stat_branches_o)
    );

    bpq_perf_counter u_stat_mispredicts (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (update_o.valid && update_o.mispredict),
        .count_o (stat_mispredicts_o)
    );
`endif

endmodule

// File: tb/tb_branch_pred_queue.sv
// tb/tb_branch_pred_queue.sv - scoreboard bench for branch_pred_queue
module tb_branch_pred_queue;
    import riscv_types_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               push_valid = 1'b0;
    logic               push_ready;
    logic [31:0]        push_pc = '0;
    branch_prediction_t push_pred = '0;
    logic               resolve_valid = 1'b0;
    logic               resolve_taken = 1'b0;
    logic [31:0]        resolve_target = '0;
    logic               flush = 1'b0;
    branch_update_t     update;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               resolve_err;
    logic [3:0]         count;
`ifdef BPQ_STATS_EN
    logic [31:0]        stat_branches;
    logic [31:0]        stat_mispredicts;
`endif

    branch_pred_queue #(.ADDR_WIDTH(32), .DEPTH(8)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .push_valid_i     (push_valid),
        .push_ready_o     (push_ready),
        .push_pc_i        (push_pc),
        .push_pred_i      (push_pred),
        .resolve_valid_i  (resolve_valid),
        .resolve_taken_i  (resolve_taken),
        .resolve_target_i (resolve_target),
        .flush_i          (flush),
        .update_o         (update),
        .redirect_o       (redirect),
        .redirect_pc_o    (redirect_pc),
        .resolve_err_o    (resolve_err),
        .count_o          (count)
`ifdef BPQ_STATS_EN
        ,
        .stat_branches_o    (stat_branches),
        .stat_mispredicts_o (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        mis;
        logic [31:0] rpc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   exp_br = 0;
    int   exp_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, req);
        end
    endtask

    task automatic expect_upd(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                              input logic mis, input logic [31:0] rpc);
        exp_t e;
        e.pc = pc; e.taken = taken; e.target = target; e.mis = mis; e.rpc = rpc;
        sbq.push_back(e);
        exp_br++;
        if (mis) exp_mis++;
    endtask

    // monitor: every update/redirect the DUT presents must match the next scoreboard entry
    always @(negedge clk) begin
        if (update.valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_update_pc", update.pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("upd_pc", update.pc, e.pc);
                chk("upd_taken", 32'(update.taken), 32'(e.taken));
                chk("upd_target", update.target, e.target);
                chk("upd_mispredict", 32'(update.mispredict), 32'(e.mis));
                chk("redirect", 32'(redirect), 32'(e.mis));
                if (e.mis) chk("redirect_pc", redirect_pc, e.rpc);
            end
        end else if (redirect) begin
            chk("redirect_without_update", 32'(redirect), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_valid = 1'b0;
        resolve_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic drive_push(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        push_valid = 1'b1;
        push_pc = pc;
        push_pred = '{predict_taken: t, predict_target: tgt, btb_hit: 1'b1};
    endtask

    task automatic drive_resolve(input logic t, input logic [31:0] tgt);
        resolve_valid = 1'b1;
        resolve_taken = t;
        resolve_target = tgt;
    endtask

    task automatic push1(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        drive_push(pc, t, tgt);
        step();
        idle();
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        step();

        // reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(push_ready), 1);
        chk("rst_update_valid", 32'(update.valid), 0);
        chk("rst_redirect", 32'(redirect), 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_err", 32'(resolve_err), 0);

        // async reset mid-operation with a pending resolve: no update emitted
        push1(32'h50, 1'b0, 32'h0);
        push1(32'h54, 1'b0, 32'h0);
        chk("pre_rst_count", 32'(count), 2);
        drive_resolve(1'b1, 32'h999);
        rst = 1'b1;
        #2;
        chk("async_rst_count", 32'(count), 0);
        step();
        idle();
        rst = 1'b0;
        step();
        chk("post_rst_count", 32'(count), 0);

        // fill to DEPTH, 9th push refused
        for (int i = 0; i < 8; i++) push1(32'h1000 + 32'(i) * 4, 1'b0, 32'h0);
        chk("full_count", 32'(count), 8);
        chk("full_ready", 32'(push_ready), 0);
        push1(32'h2000, 1'b0, 32'h0);
        chk("ninth_push_count", 32'(count), 8);
        // no full-bypass: push alongside a resolve at DEPTH is still refused
        drive_push(32'h2004, 1'b0, 32'h0);
        drive_resolve(1'b0, 32'h0);
        expect_upd(32'h1000, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        idle();
        chk("full_bypass_count", 32'(count), 7);
        for (int i = 1; i < 8; i++) begin
            drive_resolve(1'b0, 32'h0);
            expect_upd(32'h1000 + 32'(i) * 4, 1'b0, 32'h0, 1'b0, 32'h0);
            step();
            idle();
        end
        chk("drained_count", 32'(count), 0);

        // correct taken prediction; then push+resolve together keeps count
        push1(32'h100, 1'b1, 32'h200);
        drive_push(32'h180, 1'b0, 32'h0);
        drive_resolve(1'b1, 32'h200);
        expect_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        step();
        idle();
        chk("push_resolve_count", 32'(count), 1);
        chk("correct_no_redirect", 32'(redirect), 0);
        drive_resolve(1'b0, 32'h0);
        expect_upd(32'h180, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        idle();
        chk("after_correct_count", 32'(count), 0);

        // direction mispredict: predicted taken, actually not taken
        push1(32'h100, 1'b1, 32'h200);
        drive_resolve(1'b0, 32'h0);
        expect_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h104);
        step();
        idle();
        chk("dir_mis_redirect", 32'(redirect), 1);
        chk("dir_mis_pc", redirect_pc, 32'h104);
        chk("dir_mis_count", 32'(count), 0);
        step();
        chk("redirect_one_cycle", 32'(redirect), 0);

        // target mispredict with same-cycle push that must be dropped
        push1(32'h400, 1'b1, 32'h200);
        push1(32'h404, 1'b1, 32'h200);
        push1(32'h408, 1'b1, 32'h200);
        drive_push(32'h40C, 1'b0, 32'h0);
        drive_resolve(1'b1, 32'h300);
        expect_upd(32'h400, 1'b1, 32'h300, 1'b1, 32'h300);
        step();
        idle();
        chk("tgt_mis_pc", redirect_pc, 32'h300);
        chk("tgt_mis_count", 32'(count), 0);
        push1(32'h500, 1'b0, 32'h0);
        drive_resolve(1'b0, 32'h0);
        expect_upd(32'h500, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        idle();

        // flush with a same-cycle resolve: no update, no redirect
        for (int i = 0; i < 4; i++) push1(32'h700 + 32'(i) * 4, 1'b1, 32'h800);
        chk("pre_flush_count", 32'(count), 4);
        flush = 1'b1;
        drive_resolve(1'b0, 32'h0);
        step();
        idle();
        chk("flush_count", 32'(count), 0);
        chk("flush_redirect", 32'(redirect), 0);
        chk("flush_update", 32'(update.valid), 0);
        chk("flush_no_err", 32'(resolve_err), 0);

        // resolve on empty queue: sticky error; push in same cycle is kept
        drive_resolve(1'b1, 32'h0);
        step();
        idle();
        chk("empty_err", 32'(resolve_err), 1);
        step();
        step();
        chk("err_sticky", 32'(resolve_err), 1);
        drive_push(32'h600, 1'b0, 32'h0);
        drive_resolve(1'b0, 32'h0);
        step();
        idle();
        chk("empty_push_kept", 32'(count), 1);
        drive_resolve(1'b0, 32'h0);
        expect_upd(32'h600, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        idle();
        step();
        step();
        chk("scoreboard_drained", 32'(sbq.size()), 0);
        chk("final_err", 32'(resolve_err), 1);
`ifdef BPQ_STATS_EN
        chk("stat_branches", stat_branches, 32'(exp_br));
        chk("stat_mispredicts", stat_mispredicts, 32'(exp_mis));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
